fft_frame_scheduler: RTL and testbench
======================================

Name: fft_frame_scheduler

Overview:
- Sequences ADC samples from ad_data_1/ad_data_2 into the single shared FFT core of the spectrum analyzer.
- Selects the channel, decimates, converts to signed, frames FFT_LEN samples with tlast, and issues the per-frame FFT config handshake.
- Waits for FFT completion, then observes a holdoff before the next frame.
- Sits between the AD capture pins and the FFT core in ad_da_hdmi_top, in the ad_clk domain.

Parameters:
- FFT_LEN, 1024, samples per frame (power of 2).
- DATA_W, 16, ADC sample width.
- DEC_W, 8, width of decimation ratio.
- HOLDOFF, 16, idle ad_clk cycles between FFT done and next config.

Ports:
- ad_clk  in  1  sample clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; run continuous frames while high.
- ch_mode  in  2  00=ch1, 01=ch2, 10=alternate ch1/ch2 per frame, 11=treated as 00.
- dec_ratio  in  DEC_W  keep 1 of (dec_ratio+1) samples.
- ad_data_1  in  DATA_W  channel 1 sample, offset binary.
- ad_data_2  in  DATA_W  channel 2 sample, offset binary.
- fft_cfg_valid  out  1  config request to FFT core.
- fft_cfg_ready  in  1  FFT accepts config.
- fft_tvalid  out  1  sample valid.
- fft_tready  in  1  FFT accepts sample.
- fft_tdata  out  2*DATA_W  {imag=0, real=signed sample}, real in low half.
- fft_tlast  out  1  high with the FFT_LEN-th sample.
- fft_done  in  1  one-cycle pulse when FFT output frame is complete.
- frame_ch  out  1  channel of current/last frame (0=ch1, 1=ch2).
- busy  out  1  high in any state except IDLE.
- overrun_cnt  out  16  dropped-sample count (see Optional Feature).

Behaviour:
- Reset: state IDLE; all outputs 0; sample counter, decimation counter and holdoff counter 0; frame_ch 0.
- Conversion: real = {~s[DATA_W-1], s[DATA_W-2:0]}, so 16'h0000 maps to 16'h8000 and 16'h8000 maps to 16'h0000.
- IDLE: when enable=1, go to CFG. Latch ch_mode and dec_ratio (frozen for the whole frame). frame_ch = 1 if ch_mode=01, else 0.
- CFG: fft_cfg_valid=1 until a cycle with fft_cfg_ready=1. Then cfg_valid drops next cycle; go to FILL with sample_cnt=0 and dec_cnt=0.
- FILL:
  - Each cycle, dec_cnt increments. When dec_cnt == latched dec_ratio, dec_cnt wraps to 0 and the sample is taken.
  - A taken sample is registered into fft_tdata with fft_tvalid=1 on the next edge (1-cycle latency). The sample comes from the frame_ch channel.
  - tvalid/tdata/tlast hold stable until a cycle with tvalid & tready.
  - A new sample taken while the previous one is still unaccepted is dropped and overrun increments. Data is never overwritten.
  - fft_tlast=1 when sample_cnt == FFT_LEN-1.
  - On acceptance of the tlast beat: tvalid=0, go to WAIT_DONE.
- WAIT_DONE: wait for fft_done. A fft_done pulse arriving in any other state is ignored.
- HOLD: count HOLDOFF cycles. Then:
  - If alternate mode, toggle frame_ch.
  - If enable=1, go to CFG and re-latch ch_mode/dec_ratio; in non-alternate mode frame_ch is set from ch_mode.
  - If enable=0, go to IDLE.
- enable=0 mid-frame: the frame is completed normally (FFT requires full frames); stop at the end of HOLD.
- dec_ratio=0: every ad_clk sample is taken.
- Asynchronous reset mid-frame: returns to IDLE immediately and drops tvalid. The FFT core is reset by the same rst_n.

Optional Feature:
- Macro SCHED_OVERRUN_CNT_EN.
- Defined: overrun_cnt counts dropped samples, saturates at 16'hFFFF, and clears on entry to CFG.
- Undefined: overrun_cnt tied to 0 and no counter logic is generated.

Test Plan:
- ch_mode=00, dec_ratio=0, tready=1, ad_data_1 ramp from 0 -> cfg handshake, then 1024 beats with real = ramp^16'h8000, tlast on beat 1024 only, then WAIT_DONE; fft_done pulse plus 16 cycles -> next cfg_valid.
- ch_mode=10, enable held -> frame_ch sequence 0,1,0 over three frames; data taken from the matching channel.
- dec_ratio=3, tready=1 -> tvalid high 1 cycle in 4; frame spans 4096 ad_clk cycles.
- dec_ratio=0, tready low for 5 cycles mid-frame -> tdata held stable, 5 samples dropped, overrun_cnt=5 (macro defined) or 0 (undefined).
- enable dropped at sample 500 -> frame completes with 1024 beats; after done plus holdoff -> IDLE, busy=0.
- rst_n asserted at sample 300 -> tvalid=0 and busy=0 immediately; after release with enable=1 -> new cfg and sample_cnt restarts at 0.

Source files
------------

// File: rtl/fft_frame_scheduler.sv
// Frames decimated, sign-converted ADC samples into the shared FFT core with per-frame config handshake.
// Optional dropped-sample counter enabled by defining SCHED_OVERRUN_CNT_EN.
module fft_frame_scheduler #(
  parameter int FFT_LEN = 1024,
  parameter int DATA_W  = 16,
  parameter int DEC_W   = 8,
  parameter int HOLDOFF = 16
) (
  input  logic                  ad_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            ch_mode,
  input  logic [DEC_W-1:0]      dec_ratio,
  input  logic [DATA_W-1:0]     ad_data_1,
  input  logic [DATA_W-1:0]     ad_data_2,
  output logic                  fft_cfg_valid,
  input  logic                  fft_cfg_ready,
  output logic                  fft_tvalid,
  input  logic                  fft_tready,
  output logic [2*DATA_W-1:0]   fft_tdata,
  output logic                  fft_tlast,
  input  logic                  fft_done,
  output logic                  frame_ch,
  output logic                  busy,
  output logic [15:0]           overrun_cnt
);

  localparam int CNT_W  = $clog2(FFT_LEN) + 1;
  localparam int HOLD_W = $clog2(HOLDOFF + 1);
  localparam logic [1:0] MODE_CH2 = 2'b01;
  localparam logic [1:0] MODE_ALT = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_FILL, S_WAIT_DONE, S_HOLD} state_t;

  state_t              state_q;
  logic [1:0]          ch_mode_q;
  logic [DEC_W-1:0]    dec_ratio_q;
  logic [DEC_W-1:0]    dec_cnt_q;
  logic [CNT_W-1:0]    sample_cnt_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic                cfg_valid_q;
  logic                tvalid_q;
  logic                tlast_q;
  logic [2*DATA_W-1:0] tdata_q;
  logic                frame_ch_q;
  logic                busy_q;

  logic [DATA_W-1:0]   raw_sample;
  logic [DATA_W-1:0]   real_sample;
  logic                take;
  logic                accept;
  logic                load;
  logic                hold_done;
  logic                ch_after;

  assign raw_sample  = frame_ch_q ? ad_data_2 : ad_data_1;
  assign real_sample = {~raw_sample[DATA_W-1], raw_sample[DATA_W-2:0]};
  // Once the whole frame is loaded, further decimation ticks take nothing.
  assign take      = (state_q == S_FILL) && (dec_cnt_q == dec_ratio_q) &&
                     (sample_cnt_q < CNT_W'(FFT_LEN));
  assign accept    = tvalid_q && fft_tready;
  assign load      = take && (!tvalid_q || fft_tready);
  assign hold_done = (state_q == S_HOLD) && (hold_cnt_q == HOLD_W'(HOLDOFF - 1));
  assign ch_after  = frame_ch_q ^ (ch_mode_q == MODE_ALT);

  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ch_mode_q    <= '0;
      dec_ratio_q  <= '0;
      dec_cnt_q    <= '0;
      sample_cnt_q <= '0;
      hold_cnt_q   <= '0;
      cfg_valid_q  <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      frame_ch_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q     <= S_CFG;
            cfg_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            ch_mode_q   <= ch_mode;
            dec_ratio_q <= dec_ratio;
            frame_ch_q  <= (ch_mode == MODE_CH2);
          end
        end
        S_CFG: begin
          if (fft_cfg_ready) begin
            state_q      <= S_FILL;
            cfg_valid_q  <= 1'b0;
            sample_cnt_q <= '0;
            dec_cnt_q    <= '0;
          end
        end
        S_FILL: begin
          dec_cnt_q <= (dec_cnt_q == dec_ratio_q) ? '0 : dec_cnt_q + DEC_W'(1);
          if (load) begin
            tdata_q      <= {{DATA_W{1'b0}}, real_sample};
            tvalid_q     <= 1'b1;
            tlast_q      <= (sample_cnt_q == CNT_W'(FFT_LEN - 1));
            sample_cnt_q <= sample_cnt_q + CNT_W'(1);
          end else if (accept) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            if (tlast_q) state_q <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (fft_done) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= '0;
          end
        end
        S_HOLD: begin
          if (hold_done) begin
            if (enable) begin
              state_q     <= S_CFG;
              cfg_valid_q <= 1'b1;
              ch_mode_q   <= ch_mode;
              dec_ratio_q <= dec_ratio;
              frame_ch_q  <= (ch_mode == MODE_ALT) ? ch_after : (ch_mode == MODE_CH2);
            end else begin
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
              frame_ch_q <= ch_after;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SCHED_OVERRUN_CNT_EN
  logic [15:0] overrun_q;
  logic        enter_cfg;
  logic        drop;

  assign enter_cfg = enable && ((state_q == S_IDLE) || hold_done);
  assign drop      = take && tvalid_q && !fft_tready;

  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= '0;
    end else if (enter_cfg) begin
      overrun_q <= '0;
    end else if (drop && (overrun_q != 16'hFFFF)) begin
      overrun_q <= overrun_q + 16'd1;
    end
  end

  assign overrun_cnt = overrun_q;
`else
  assign overrun_cnt = 16'h0000;
`endif

  assign fft_cfg_valid = cfg_valid_q;
  assign fft_tvalid    = tvalid_q;
  assign fft_tlast     = tlast_q;
  assign fft_tdata     = tdata_q;
  assign frame_ch      = frame_ch_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Randomized-data bench for fft_frame_scheduler; a frame-level reference model predicts every beat.
`timescale 1ns/1ps
module tb_fft_frame_scheduler;

  localparam int LEN     = 1024;
  localparam int HOLDOFF = 16;

  logic        ad_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  ch_mode = 2'b00;
  logic [7:0]  dec_ratio = 8'd0;
  logic [15:0] ad_data_1 = 16'h0;
  logic [15:0] ad_data_2 = 16'h0;
  logic        fft_cfg_ready = 1'b0;
  logic        fft_tready = 1'b0;
  logic        fft_done = 1'b0;
  logic        fft_cfg_valid;
  logic        fft_tvalid;
  logic [31:0] fft_tdata;
  logic        fft_tlast;
  logic        frame_ch;
  logic        busy;
  logic [15:0] overrun_cnt;

  int total = 0;
  int bad = 0;
  int cur_mode, cur_d, cur_ch, prev_mode, prev_ch;
  bit from_idle;

  fft_frame_scheduler dut (
    .ad_clk(ad_clk), .rst_n(rst_n), .enable(enable), .ch_mode(ch_mode),
    .dec_ratio(dec_ratio), .ad_data_1(ad_data_1), .ad_data_2(ad_data_2),
    .fft_cfg_valid(fft_cfg_valid), .fft_cfg_ready(fft_cfg_ready),
    .fft_tvalid(fft_tvalid), .fft_tready(fft_tready), .fft_tdata(fft_tdata),
    .fft_tlast(fft_tlast), .fft_done(fft_done), .frame_ch(frame_ch),
    .busy(busy), .overrun_cnt(overrun_cnt)
  );

  always #5 ad_clk = ~ad_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ad_clk);
    @(negedge ad_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_signed(input logic [15:0] s);
    return s ^ 16'h8000;
  endfunction

  // One complete frame from the CFG request through the holdoff; returns early on a planted reset.
  task automatic run_frame(input logic [1:0] nmode, input logic [7:0] nd, input int stall_at,
                           input int stall_len, input bit rnd_rdy, input int en_drop_at,
                           input int rst_at);
    int n, j, loaded, drops, stall_rem, limit, exp_ch, t, exp_ovr;
    bit pend, pend_last, accept, take, done_frame, stalled;
    logic [15:0] pend_val, d1, d2;
    logic rdy;

    n = 0;
    while (fft_cfg_valid !== 1'b1 && n < 16) begin tick(); n++; end
    check("cfg_valid_rise", 32'(fft_cfg_valid), 32'd1);
    cur_mode = int'(ch_mode);
    cur_d    = int'(dec_ratio);
    if (from_idle) exp_ch = (cur_mode == 1) ? 1 : 0;
    else begin
      t = prev_ch ^ ((prev_mode == 2) ? 1 : 0);
      exp_ch = (cur_mode == 2) ? t : ((cur_mode == 1) ? 1 : 0);
    end
    cur_ch = exp_ch;
    check("frame_ch", 32'(frame_ch), 32'(exp_ch));
    check("busy_cfg", 32'(busy), 32'd1);
    check("overrun_clear", 32'(overrun_cnt), 32'd0);

    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      fft_done = (i == 0);
      tick();
      check("cfg_valid_hold", 32'(fft_cfg_valid), 32'd1);
    end
    fft_done = 1'b0;
    fft_cfg_ready = 1'b1;
    tick();
    fft_cfg_ready = 1'b0;
    check("cfg_valid_drop", 32'(fft_cfg_valid), 32'd0);
    check("tvalid_pre_fill", 32'(fft_tvalid), 32'd0);

    pend = 0; pend_last = 0; pend_val = '0; loaded = 0; drops = 0; j = 0;
    stall_rem = 0; stalled = 0; done_frame = 0;
    limit = 8 * LEN * (cur_d + 1) + 100;
    while (!done_frame && j < limit) begin
      if (rst_at >= 0 && loaded == rst_at) begin
        ch_mode = nmode; dec_ratio = nd; fft_tready = 1'b1; fft_done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_tvalid", 32'(fft_tvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_valid", 32'(fft_cfg_valid), 32'd0);
        check("rst_frame_ch", 32'(frame_ch), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        from_idle = 1;
        return;
      end
      if (loaded == stall_at && !stalled) begin stall_rem = stall_len; stalled = 1; end
      rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stall_rem > 0) begin rdy = 1'b0; stall_rem--; end
      if (en_drop_at >= 0 && loaded >= en_drop_at) enable = 1'b0;
      d1 = 16'($urandom);
      d2 = 16'($urandom);
      ad_data_1 = d1; ad_data_2 = d2;
      fft_tready = rdy;
      fft_done = (j == 7);
      ch_mode = 2'($urandom);
      dec_ratio = 8'($urandom);

      accept = pend && rdy;
      if (accept && pend_last) done_frame = 1;
      take = ((j % (cur_d + 1)) == cur_d) && (loaded < LEN);
      if (take && pend && !accept) drops++;
      else if (take) begin
        pend_val  = to_signed(cur_ch != 0 ? d2 : d1);
        pend_last = (loaded == LEN - 1);
        loaded++;
        pend = 1;
      end else if (accept) pend = 0;

      tick();
      j++;
      check("tvalid", 32'(fft_tvalid), 32'(pend));
      if (pend) begin
        check("tdata", fft_tdata, {16'h0000, pend_val});
        check("tlast", 32'(fft_tlast), 32'(pend_last));
      end
    end
    fft_done = 1'b0;
    ch_mode = nmode;
    dec_ratio = nd;
    check("frame_complete", 32'(done_frame), 32'd1);
    if (stall_len == 0 && !rnd_rdy) check("fill_span", 32'(j), 32'(LEN * (cur_d + 1) + 1));

`ifdef SCHED_OVERRUN_CNT_EN
    exp_ovr = (drops > 65535) ? 65535 : drops;
`else
    exp_ovr = 0;
`endif
    check("overrun_cnt", 32'(overrun_cnt), 32'(exp_ovr));

    n = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) begin
      tick();
      check("wait_busy", 32'(busy), 32'd1);
      check("wait_tvalid", 32'(fft_tvalid), 32'd0);
      check("wait_cfg_valid", 32'(fft_cfg_valid), 32'd0);
    end
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    n = 0;
    while (n < 100 && !(enable ? (fft_cfg_valid === 1'b1) : (busy === 1'b0))) begin
      tick();
      n++;
    end
    check("holdoff_cycles", 32'(n), 32'(HOLDOFF));
    if (!enable) begin
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_cfg_valid", 32'(fft_cfg_valid), 32'd0);
    end
    $display("frame mode=%0d dec=%0d ch=%0d fill_cycles=%0d drops=%0d holdoff=%0d",
             cur_mode, cur_d, cur_ch, j, drops, n);
    prev_mode = cur_mode;
    prev_ch   = cur_ch;
    from_idle = !enable;
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    check("reset_cfg_valid", 32'(fft_cfg_valid), 32'd0);
    check("reset_tvalid", 32'(fft_tvalid), 32'd0);
    check("reset_tlast", 32'(fft_tlast), 32'd0);
    check("reset_tdata", fft_tdata, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_ch", 32'(frame_ch), 32'd0);
    check("reset_overrun", 32'(overrun_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_without_enable", 32'(busy), 32'd0);

    ch_mode = 2'b00; dec_ratio = 8'd0; enable = 1'b1; from_idle = 1;
    run_frame(2'b10, 8'd0, -1, 0, 0, -1, -1);   // ch1, every sample
    run_frame(2'b10, 8'd0, -1, 0, 0, -1, -1);   // alternate: ch 0
    run_frame(2'b10, 8'd0, -1, 0, 0, -1, -1);   // alternate: ch 1
    run_frame(2'b00, 8'd3, -1, 0, 0, -1, -1);   // alternate: ch 0
    run_frame(2'b00, 8'd0, -1, 0, 0, -1, -1);   // decimate by 4
    run_frame(2'b01, 8'd1, 200, 5, 0, -1, -1);  // 5-cycle stall
    run_frame(2'b11, 8'd0, -1, 0, 1, -1, -1);   // ch2, random tready
    run_frame(2'b00, 8'd0, -1, 0, 0, 500, -1);  // mode 11 as ch1, enable dropped
    enable = 1'b1;
    run_frame(2'b00, 8'd0, -1, 0, 0, -1, 300);  // reset mid-frame
    run_frame(2'b00, 8'd0, -1, 0, 0, 0, -1);    // restart, then stop

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
